// File: rtl/lcd_pkg.sv
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared sync-mode codes, reset level and RGB565 test-bar colours.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

  localparam logic RstEnable = 1'b1;

  localparam int LCD_SYNC_DE = 0;
  localparam int LCD_SYNC_HV = 1;

  localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB565_RED     = 16'hF800;
  localparam logic [15:0] RGB565_BLUE    = 16'h001F;
  localparam logic [15:0] RGB565_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] col;
    col = RGB565_BLACK;
    case (idx)
      3'd0:    col = RGB565_WHITE;
      3'd1:    col = RGB565_YELLOW;
      3'd2:    col = RGB565_CYAN;
      3'd3:    col = RGB565_GREEN;
      3'd4:    col = RGB565_MAGENTA;
      3'd5:    col = RGB565_RED;
      3'd6:    col = RGB565_BLUE;
      default: col = RGB565_BLACK;
    endcase
    return col;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_tile_map.sv
// ============================================================================
// Module   : lcd_tile_map
// Purpose  : Registers the column-major tile offset for the requested pixel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_tile_map
  import lcd_pkg::*;
#(
  parameter int TILE_COLS     = 5,
  parameter int TILE_ROWS     = 3,
  parameter int OFFSET_STRIDE = 2,
  parameter int H_DISP        = 480,
  parameter int V_DISP        = 272,
  parameter int CW            = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] pix_x,
  input  logic [CW-1:0] pix_y,
  output logic [CW-1:0] tile_offset
);

  localparam logic [CW-1:0] c_col_w   = CW'(H_DISP / TILE_COLS);
  localparam logic [CW-1:0] c_row_h   = CW'(V_DISP / TILE_ROWS);
  localparam logic [CW-1:0] c_col_max = CW'(TILE_COLS - 1);
  localparam logic [CW-1:0] c_row_max = CW'(TILE_ROWS - 1);
  localparam logic [CW-1:0] c_rows    = CW'(TILE_ROWS);
  localparam logic [CW-1:0] c_stride  = CW'(OFFSET_STRIDE);

  logic [CW-1:0] w_col_raw;
  logic [CW-1:0] w_row_raw;
  logic [CW-1:0] w_col;
  logic [CW-1:0] w_row;

  // Remainder pixels past the last full tile are folded into the last column/row.
  assign w_col_raw = pix_x / c_col_w;
  assign w_row_raw = pix_y / c_row_h;
  assign w_col     = (w_col_raw > c_col_max) ? c_col_max : w_col_raw;
  assign w_row     = (w_row_raw > c_row_max) ? c_row_max : w_row_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      tile_offset <= '0;
    end else begin
      tile_offset <= (w_col * c_rows + w_row) * c_stride;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_timing_tiler.sv
// ============================================================================
// Module   : lcd_timing_tiler
// Purpose  : RGB LCD timing generator with tile-offset addressing and underflow
//            detection. Optional test_mode bar pattern under LCD_TEST_PATTERN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_timing_tiler
  import lcd_pkg::*;
#(
  parameter int            DW              = 16,
  parameter int            CW              = 11,
  parameter int            H_SYNC          = 41,
  parameter int            H_BACK          = 2,
  parameter int            H_DISP          = 480,
  parameter int            H_FRONT         = 2,
  parameter int            V_SYNC          = 10,
  parameter int            V_BACK          = 2,
  parameter int            V_DISP          = 272,
  parameter int            V_FRONT         = 2,
  parameter int            TILE_COLS       = 5,
  parameter int            TILE_ROWS       = 3,
  parameter int            OFFSET_STRIDE   = 2,
  parameter int            SYNC_MODE       = 0,
  parameter bit            HS_POL          = 1'b0,
  parameter bit            VS_POL          = 1'b0,
  parameter logic [DW-1:0] UNDERFLOW_COLOR = 16'hF800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] rgb_data,
  input  logic          rgb_valid,
  input  logic          clr_underflow,
  output logic          pix_req,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic [CW-1:0] tile_offset,
  output logic          lcd_hs,
  output logic          lcd_vs,
  output logic          lcd_de,
  output logic [DW-1:0] lcd_rgb,
  output logic          frame_start,
  output logic          underflow
`ifdef LCD_TEST_PATTERN_EN
  ,
  input  logic          test_mode
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [CW-1:0] c_h_last = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] c_v_last = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] c_h_act0 = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] c_h_act1 = CW'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CW-1:0] c_h_req0 = CW'(H_SYNC + H_BACK - 1);
  localparam logic [CW-1:0] c_h_req1 = CW'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [CW-1:0] c_v_act0 = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] c_v_act1 = CW'(V_SYNC + V_BACK + V_DISP);
  localparam logic [CW-1:0] c_h_sync = CW'(H_SYNC);
  localparam logic [CW-1:0] c_v_sync = CW'(V_SYNC);

  if (H_DISP < TILE_COLS) begin : g_chk_hdisp
    $error("lcd_timing_tiler: H_DISP must be >= TILE_COLS");
  end
  if (V_DISP < TILE_ROWS) begin : g_chk_vdisp
    $error("lcd_timing_tiler: V_DISP must be >= TILE_ROWS");
  end
  if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_chk_total
    $error("lcd_timing_tiler: H_TOTAL/V_TOTAL must be < 2**CW");
  end
  if (H_SYNC + H_BACK < 1) begin : g_chk_lead
    $error("lcd_timing_tiler: H_SYNC+H_BACK must be >= 1 for the request lead");
  end

  logic [CW-1:0] r_cnt_h;
  logic [CW-1:0] r_cnt_v;
  logic          w_h_act;
  logic          w_h_req;
  logic          w_v_act;
  logic          w_test_mode;
  logic [DW-1:0] w_tp_rgb;
  logic [DW-1:0] w_rgb;
  logic          w_uf_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else if (!en) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else if (r_cnt_h == c_h_last) begin
      r_cnt_h <= '0;
      r_cnt_v <= (r_cnt_v == c_v_last) ? '0 : r_cnt_v + CW'(1);
    end else begin
      r_cnt_h <= r_cnt_h + CW'(1);
    end
  end

  assign w_h_act = (r_cnt_h >= c_h_act0) && (r_cnt_h < c_h_act1);
  assign w_h_req = (r_cnt_h >= c_h_req0) && (r_cnt_h < c_h_req1);
  assign w_v_act = (r_cnt_v >= c_v_act0) && (r_cnt_v < c_v_act1);

  // en gates the decodes so the cycle in which en drops is already blank.
  assign lcd_de      = en && w_h_act && w_v_act;
  assign pix_req     = en && w_h_req && w_v_act;
  assign frame_start = en && (r_cnt_h == '0) && (r_cnt_v == '0);
  assign pix_x       = pix_req ? (r_cnt_h - c_h_req0) : '0;
  assign pix_y       = pix_req ? (r_cnt_v - c_v_act0) : '0;

  lcd_tile_map #(
    .TILE_COLS     (TILE_COLS),
    .TILE_ROWS     (TILE_ROWS),
    .OFFSET_STRIDE (OFFSET_STRIDE),
    .H_DISP        (H_DISP),
    .V_DISP        (V_DISP),
    .CW            (CW)
  ) u_tile_map (
    .clk         (clk),
    .rst         (rst),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .tile_offset (tile_offset)
  );

  if (SYNC_MODE == LCD_SYNC_HV) begin : g_sync_hv
    assign lcd_hs = (r_cnt_h < c_h_sync) ? HS_POL : ~HS_POL;
    assign lcd_vs = (r_cnt_v < c_v_sync) ? VS_POL : ~VS_POL;
  end else begin : g_sync_de
    assign lcd_hs = 1'b1;
    assign lcd_vs = 1'b1;
  end

`ifdef LCD_TEST_PATTERN_EN
  logic [2:0] r_bar;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_bar <= '0;
    end else begin
      r_bar <= 3'(({pix_x, 3'b000}) / (CW + 3)'(H_DISP));
    end
  end

  assign w_test_mode = test_mode;
  assign w_tp_rgb    = DW'(bar_color(r_bar));
`else
  assign w_test_mode = 1'b0;
  assign w_tp_rgb    = '0;
`endif

  always_comb begin
    w_rgb    = '0;
    w_uf_set = 1'b0;
    if (lcd_de) begin
      if (w_test_mode) begin
        w_rgb = w_tp_rgb;
      end else if (rgb_valid) begin
        w_rgb = rgb_data;
      end else begin
        w_rgb    = UNDERFLOW_COLOR;
        w_uf_set = 1'b1;
      end
    end
  end

  assign lcd_rgb = w_rgb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      underflow <= 1'b0;
    end else if (w_uf_set) begin
      underflow <= 1'b1;
    end else if (clr_underflow) begin
      underflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_timing_tiler.sv
// ============================================================================
// Module   : tb_lcd_timing_tiler
// Purpose  : Directed self-checking bench for lcd_timing_tiler (small panel).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_timing_tiler;

  localparam int DW = 16;
  localparam int CW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic rgb_valid = 1'b1;
  logic clr_underflow = 1'b0;
`ifdef LCD_TEST_PATTERN_EN
  logic test_mode = 1'b0;
`endif

  wire [DW-1:0] rgb_data;
  wire          pix_req, lcd_hs, lcd_vs, lcd_de, frame_start, underflow;
  wire [CW-1:0] pix_x, pix_y, tile_offset;
  wire [DW-1:0] lcd_rgb;

  wire          d_pix_req, d_lcd_hs, d_lcd_vs, d_lcd_de, d_frame_start, d_underflow;
  wire [CW-1:0] d_pix_x, d_pix_y, d_tile_offset;
  wire [DW-1:0] d_lcd_rgb;

  // Combinational memory: tag the returned pixel with its offset.
  assign rgb_data = {5'h14, tile_offset};

  always #5 clk = ~clk;

  lcd_timing_tiler #(
    .DW(DW), .CW(CW),
    .H_SYNC(2), .H_BACK(1), .H_DISP(8), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .TILE_COLS(2), .TILE_ROWS(2), .OFFSET_STRIDE(2),
    .SYNC_MODE(1), .HS_POL(1'b0), .VS_POL(1'b0), .UNDERFLOW_COLOR(16'hF800)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .rgb_data(rgb_data), .rgb_valid(rgb_valid),
    .clr_underflow(clr_underflow), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .tile_offset(tile_offset), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
    .lcd_rgb(lcd_rgb), .frame_start(frame_start), .underflow(underflow)
`ifdef LCD_TEST_PATTERN_EN
    , .test_mode(test_mode)
`endif
  );

  lcd_timing_tiler #(
    .DW(DW), .CW(CW),
    .H_SYNC(2), .H_BACK(1), .H_DISP(8), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .TILE_COLS(2), .TILE_ROWS(2), .OFFSET_STRIDE(2),
    .SYNC_MODE(0), .HS_POL(1'b0), .VS_POL(1'b0), .UNDERFLOW_COLOR(16'hF800)
  ) u_dut_de (
    .clk(clk), .rst(rst), .en(en), .rgb_data(rgb_data), .rgb_valid(rgb_valid),
    .clr_underflow(clr_underflow), .pix_req(d_pix_req), .pix_x(d_pix_x), .pix_y(d_pix_y),
    .tile_offset(d_tile_offset), .lcd_hs(d_lcd_hs), .lcd_vs(d_lcd_vs), .lcd_de(d_lcd_de),
    .lcd_rgb(d_lcd_rgb), .frame_start(d_frame_start), .underflow(d_underflow)
`ifdef LCD_TEST_PATTERN_EN
    , .test_mode(test_mode)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int mh = 0;
  int mv = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (h=%0d v=%0d): got 0x%0h expected 0x%0h", tag, mh, mv, got, exp);
    end
  endtask

  // Small panel: H_TOTAL=12 (DE at h 3..10), V_TOTAL=7 (DE lines 2..5).
  function automatic logic f_de(input int h, input int v);
    return (h >= 3) && (h <= 10) && (v >= 2) && (v <= 5);
  endfunction

  function automatic logic f_req(input int h, input int v);
    return (h >= 2) && (h <= 9) && (v >= 2) && (v <= 5);
  endfunction

  // 2x2 tiles of 4x2 pixels, column-major, stride 2.
  function automatic int f_off(input int h, input int v);
    return (((h - 3) >= 4) ? 4 : 0) + (((v - 2) >= 2) ? 2 : 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (mh == 11) begin
      mh = 0;
      mv = (mv == 6) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
  endtask

  task automatic goto_hv(input int h, input int v);
    while (!(mh == h && mv == v)) step();
  endtask

  task automatic check_cycle();
    chk("lcd_de", lcd_de, f_de(mh, mv));
    chk("pix_req", pix_req, f_req(mh, mv));
    chk("frame_start", frame_start, (mh == 0 && mv == 0));
    chk("pix_x", pix_x, f_req(mh, mv) ? mh - 2 : 0);
    chk("pix_y", pix_y, f_req(mh, mv) ? mv - 2 : 0);
    chk("lcd_hs", lcd_hs, (mh < 2) ? 0 : 1);
    chk("lcd_vs", lcd_vs, (mv < 1) ? 0 : 1);
    chk("de_mode_hs", d_lcd_hs, 1);
    chk("de_mode_vs", d_lcd_vs, 1);
    if (f_de(mh, mv)) begin
      chk("tile_offset", tile_offset, f_off(mh, mv));
      chk("lcd_rgb", lcd_rgb, 32'h0000A000 | f_off(mh, mv));
    end else begin
      chk("lcd_rgb_blank", lcd_rgb, 0);
    end
  endtask

`ifdef LCD_TEST_PATTERN_EN
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tile_offset", tile_offset, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_lcd_de", lcd_de, 0);
    chk("rst_pix_req", pix_req, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_lcd_rgb", lcd_rgb, 0);

    rst = 1'b0;
    en  = 1'b1;
    #1;
    mh = 0;
    mv = 0;
    for (int i = 0; i < 2 * 84; i++) begin
      check_cycle();
      step();
    end

    // Underflow set, hold, clear.
    goto_hv(5, 3);
    rgb_valid = 1'b0;
    #1;
    chk("uf_color", lcd_rgb, 16'hF800);
    step();
    rgb_valid = 1'b1;
    chk("uf_set", underflow, 1);
    step();
    chk("uf_sticky", underflow, 1);
    clr_underflow = 1'b1;
    step();
    clr_underflow = 1'b0;
    chk("uf_cleared", underflow, 0);

    // Set and clear together: set wins.
    goto_hv(4, 4);
    rgb_valid     = 1'b0;
    clr_underflow = 1'b1;
    step();
    rgb_valid     = 1'b1;
    chk("uf_set_wins", underflow, 1);
    step();
    clr_underflow = 1'b0;
    chk("uf_clear2", underflow, 0);

    // en dropped mid-line, restored after 5 cycles.
    goto_hv(6, 2);
    en = 1'b0;
    #1;
    chk("en0_de", lcd_de, 0);
    chk("en0_req", pix_req, 0);
    chk("en0_fs", frame_start, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("en0_hold_de", lcd_de, 0);
      chk("en0_hold_fs", frame_start, 0);
    end
    en = 1'b1;
    #1;
    mh = 0;
    mv = 0;
    for (int i = 0; i < 40; i++) begin
      check_cycle();
      step();
    end

    // Asynchronous reset mid-frame.
    goto_hv(8, 5);
    rgb_valid = 1'b0;
    step();
    rgb_valid = 1'b1;
    chk("pre_rst_offset", tile_offset, f_off(9, 5));
    chk("pre_rst_uf", underflow, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_offset", tile_offset, 0);
    chk("arst_uf", underflow, 0);
    chk("arst_de", lcd_de, 0);
    chk("arst_req", pix_req, 0);
    chk("arst_rgb", lcd_rgb, 0);
    chk("arst_fs", frame_start, 1);
    @(negedge clk);
    rst = 1'b0;
    mh = 0;
    mv = 0;
    for (int i = 0; i < 30; i++) begin
      check_cycle();
      step();
    end

`ifdef LCD_TEST_PATTERN_EN
    goto_hv(0, 0);
    test_mode = 1'b1;
    rgb_valid = 1'b0;
    for (int i = 0; i < 84; i++) begin
      if (f_de(mh, mv)) chk("test_bar", lcd_rgb, bars[mh - 3]);
      step();
    end
    chk("test_no_uf", underflow, 0);
    test_mode = 1'b0;
    rgb_valid = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
